// File: rtl/snake_pkg.sv
// ============================================================================
// snake_pkg : constants and types shared by the high-score tracker and reader
// Revision  : 1.0
// ============================================================================
`default_nettype none

package snake_pkg;

  localparam int NUM_ENTRIES = 5;
  localparam int SCORE_W     = 8;
  localparam int DIGITS      = 3;

  localparam int RANK_W = $clog2(NUM_ENTRIES + 1);
  localparam int POS_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2,
    DONE    = 2'd3
  } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : sequential double-dabble, one shift per clock (BIN_W cycles)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
  parameter int BIN_W = 8,
  parameter int NDIG  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [BIN_W-1:0]  bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NDIG*4-1:0] bcd_o
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [NDIG*4-1:0] bcd_q, bcd_d;
  logic [NDIG*4-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end

    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    if (load_i) begin
      cnt_d = CNT_W'(BIN_W);
      bin_d = bin_i;
      bcd_d = '0;
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      cnt_d          = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

  // done_o flags the cycle whose closing edge performs the final shift
  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CNT_W'(1));
  assign bcd_o  = bcd_q;

endmodule

`default_nettype wire

// File: rtl/highscore_reader.sv
// ============================================================================
// highscore_reader : snapshots the high-score table and streams each entry
//                    out as BCD digits, MSD first, over valid/ready.
// Option           : HIGHSCORE_READER_BLANK_EN blanks leading zeros (4'hF)
// Revision         : 1.0
// ============================================================================
`default_nettype none

module highscore_reader
  import snake_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_ENTRIES*SCORE_W-1:0] scores_flat,
  output logic                           digit_valid,
  input  logic                           digit_ready,
  output logic [RANK_W-1:0]              digit_rank,
  output logic [POS_W-1:0]               digit_pos,
  output logic [3:0]                     digit_val,
  output logic                           busy,
  output logic                           done
);

  localparam int                IDX_W     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NUM_ENTRIES);
  localparam logic [POS_W-1:0]  MSD_POS   = POS_W'(DIGITS - 1);

  rd_state_e          state_q, state_d;
  logic [RANK_W-1:0]  rank_q, rank_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [SCORE_W-1:0] snap_q [NUM_ENTRIES];
  logic [SCORE_W-1:0] snap_d [NUM_ENTRIES];

  logic [IDX_W-1:0]    next_idx;
  logic                conv_load, conv_busy, conv_done;
  logic [SCORE_W-1:0]  conv_bin;
  logic [DIGITS*4-1:0] conv_bcd;
  logic [3:0]          raw_digit, cur_digit;

  // rank_q is 1-based, so it is also the 0-based index of the following entry
  assign next_idx = (rank_q < LAST_RANK) ? IDX_W'(rank_q) : '0;

  always_comb begin
    state_d   = state_q;
    rank_d    = rank_q;
    pos_d     = pos_q;
    snap_d    = snap_q;
    conv_load = 1'b0;
    conv_bin  = snap_q[next_idx];

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_ENTRIES; i++) snap_d[i] = scores_flat[i*SCORE_W +: SCORE_W];
          conv_load = 1'b1;
          conv_bin  = scores_flat[SCORE_W-1:0];
          rank_d    = RANK_W'(1);
          pos_d     = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_busy && conv_done) begin
          pos_d   = MSD_POS;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (digit_ready) begin
          if (pos_q != '0) begin
            pos_d = pos_q - 1'b1;
          end else if (rank_q < LAST_RANK) begin
            conv_load = 1'b1;
            rank_d    = rank_q + 1'b1;
            state_d   = CONVERT;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rank_d  = '0;
        pos_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rank_q  <= '0;
      pos_q   <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rank_q  <= rank_d;
      pos_q   <= pos_d;
      snap_q  <= snap_d;
    end
  end

  bin2bcd_seq #(
    .BIN_W (SCORE_W),
    .NDIG  (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .load_i (conv_load),
    .bin_i  (conv_bin),
    .busy_o (conv_busy),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  assign raw_digit = 4'(conv_bcd >> {pos_q, 2'b00});

`ifdef HIGHSCORE_READER_BLANK_EN
  logic upper_zero;
  // a digit is leading when it and every more-significant digit are zero
  assign upper_zero = ((conv_bcd >> {pos_q, 2'b00}) == '0);
  assign cur_digit  = ((pos_q != '0) && upper_zero) ? BCD_BLANK : raw_digit;
`else
  assign cur_digit  = raw_digit;
`endif

  assign digit_valid = (state_q == EMIT);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign digit_rank  = rank_q;
  assign digit_pos   = pos_q;
  assign digit_val   = digit_valid ? cur_digit : 4'h0;

endmodule

`default_nettype wire

// File: tb/tb_highscore_reader.sv
// ============================================================================
// tb_highscore_reader : bench for highscore_reader
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_highscore_reader;
  import snake_pkg::*;

  logic                           clk = 1'b0;
  logic                           reset, start, digit_ready;
  logic [NUM_ENTRIES*SCORE_W-1:0] scores_flat;
  logic                           digit_valid, busy, done;
  logic [RANK_W-1:0]              digit_rank;
  logic [POS_W-1:0]               digit_pos;
  logic [3:0]                     digit_val;

  always #5 clk = ~clk;

  highscore_reader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .scores_flat (scores_flat),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .digit_rank  (digit_rank),
    .digit_pos   (digit_pos),
    .digit_val   (digit_val),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [SCORE_W-1:0]  score;
    logic [DIGITS*4-1:0] dec;
    logic [DIGITS*4-1:0] blk;
  } vec_t;

  typedef struct packed {
    logic [RANK_W-1:0] rank;
    logic [POS_W-1:0]  pos;
    logic [3:0]        val;
  } exp_t;

  vec_t vecs [15];
  exp_t sb [$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;
  int   n_acc = 0;
  int   n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DIGITS*4-1:0] exp_word(input vec_t v);
`ifdef HIGHSCORE_READER_BLANK_EN
    return v.blk;
`else
    return v.dec;
`endif
  endfunction

  // Scoreboard consumer: every accepted digit pops one expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (done) n_done++;
      if (digit_valid && digit_ready) begin
        n_acc++;
        if (sb.size() == 0) begin
          check("unexpected_digit", 32'd1, 32'd0);
        end else begin
          m_e = sb.pop_front();
          check("digit_rank", digit_rank, m_e.rank);
          check("digit_pos",  digit_pos,  m_e.pos);
          check("digit_val",  digit_val,  m_e.val);
        end
      end
    end
  end

  task automatic setup(input int base);
    logic [DIGITS*4-1:0] w;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      scores_flat[k*SCORE_W +: SCORE_W] = vecs[base+k].score;
      w = exp_word(vecs[base+k]);
      for (int p = DIGITS - 1; p >= 0; p--)
        sb.push_back({RANK_W'(k + 1), POS_W'(p), w[p*4 +: 4]});
    end
  endtask

  // Called just after a rising edge; ends just after a rising edge
  task automatic readout(input int base, input bit bp, input bit restart, input bit snap);
    int cyc, lat, acc0, done0;
    bit bp_done, restarted;
    logic [DIGITS*4-1:0] w1;
    bp_done = 0; restarted = 0; lat = -1;
    w1 = exp_word(vecs[base+1]);
    setup(base);
    acc0 = n_acc; done0 = n_done;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0;
    while (!done && cyc < 400) begin
      if (lat < 0 && digit_valid) lat = cyc;
      if (snap && cyc == 2) scores_flat = {NUM_ENTRIES{SCORE_W'(99)}};
      start = 1'b0;
      if (restart && !restarted && digit_valid && digit_rank == 3) begin
        start = 1'b1;
        restarted = 1;
      end
      if (bp && !bp_done && digit_valid && digit_rank == 2 && digit_pos == 1) begin
        bp_done = 1;
        digit_ready = 1'b0;
        repeat (3) begin
          @(posedge clk) #1;
          cyc++;
          check("bp_valid", digit_valid, 1);
          check("bp_rank",  digit_rank,  2);
          check("bp_pos",   digit_pos,   1);
          check("bp_val",   digit_val,   w1[7:4]);
        end
        digit_ready = 1'b1;
      end
      @(posedge clk) #1;
      cyc++;
    end
    check("done_seen", done, 1);
    check("first_valid_latency", lat, SCORE_W);
    check("done_cycle", cyc, NUM_ENTRIES * (SCORE_W + DIGITS) + (bp ? 3 : 0));
    check("busy_in_done", busy, 1);
    start = restart;
    @(posedge clk) #1;
    start = 1'b0;
    check("done_pulse_len", done, 0);
    check("busy_after_done", busy, 0);
    check("digits_accepted", n_acc - acc0, NUM_ENTRIES * DIGITS);
    check("done_pulses", n_done - done0, 1);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{8'd255, 12'h255, 12'h255};
    vecs[1]  = '{8'd120, 12'h120, 12'h120};
    vecs[2]  = '{8'd45,  12'h045, 12'hF45};
    vecs[3]  = '{8'd7,   12'h007, 12'hFF7};
    vecs[4]  = '{8'd0,   12'h000, 12'hFF0};
    vecs[5]  = '{8'd10,  12'h010, 12'hF10};
    vecs[6]  = '{8'd9,   12'h009, 12'hFF9};
    vecs[7]  = '{8'd8,   12'h008, 12'hFF8};
    vecs[8]  = '{8'd7,   12'h007, 12'hFF7};
    vecs[9]  = '{8'd6,   12'h006, 12'hFF6};
    vecs[10] = '{8'd100, 12'h100, 12'h100};
    vecs[11] = '{8'd99,  12'h099, 12'hF99};
    vecs[12] = '{8'd9,   12'h009, 12'hFF9};
    vecs[13] = '{8'd50,  12'h050, 12'hF50};
    vecs[14] = '{8'd1,   12'h001, 12'hFF1};

    reset = 1'b1; start = 1'b0; digit_ready = 1'b1; scores_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", digit_valid, 0);
    check("rst_rank",  digit_rank,  0);
    check("rst_pos",   digit_pos,   0);
    check("rst_val",   digit_val,   0);
    check("rst_busy",  busy,        0);
    check("rst_done",  done,        0);
    reset = 1'b0;
    @(posedge clk) #1;

    readout(0, 1'b0, 1'b0, 1'b0);   // reference table
    readout(5, 1'b0, 1'b0, 1'b1);   // table overwritten mid-conversion
    readout(10, 1'b0, 1'b1, 1'b0);  // start pulsed mid-EMIT and during DONE
    readout(0, 1'b1, 1'b0, 1'b0);   // backpressure at rank 2 pos 1

    // reset during rank-3 EMIT
    setup(0);
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    cyc = 0;
    while (!(digit_valid && digit_rank == 3) && cyc < 200) begin
      @(posedge clk) #1;
      cyc++;
    end
    check("reached_rank3", digit_rank, 3);
    reset = 1'b1;
    @(posedge clk) #1;
    check("midrst_valid", digit_valid, 0);
    check("midrst_busy",  busy,        0);
    check("midrst_done",  done,        0);
    check("midrst_rank",  digit_rank,  0);
    reset = 1'b0;
    sb.delete();
    @(posedge clk) #1;
    readout(0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
